nw_vc_fc_in: RTL and testbench
==============================

Name: nw_vc_fc_in

Overview:
Receiver-side virtual-channel flow control for a router input port or network-interface sink.
- Tracks per-VC input-buffer occupancy from flit arrivals and buffer dequeues.
- Returns one credit per cycle on the channel control path (credit_valid/credit) to the upstream credit counter.
- Backlogged credits are serialised with a round-robin arbiter.
- Optionally drives per-VC nearly_full for stop/go flow control.

Parameters:
num_vcs, 4, number of virtual channels
buf_depth, 4, flits per VC input FIFO; equals upstream initial credit count
vc_bits, clog2(num_vcs), width of binary credit VC index
counter_bits, clog2(buf_depth+1), occupancy and pending-credit counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset: synchronous, active-low
flit_valid  in  1  flit written into an input VC FIFO this cycle
flit_vc_id  in  num_vcs  one-hot VC of the arriving flit; ignored when flit_valid=0
vc_deq  in  num_vcs  per-VC dequeue pulses; any number of bits may be set in one cycle
credit_valid  out  1  credit returned upstream this cycle
credit  out  vc_bits  binary VC index of the returned credit
nearly_full  out  num_vcs  per-VC stop/go indication; tied 0 without NEARLY_FULL_OUT_EN
vc_occupancy  out  num_vcs*counter_bits  per-VC flits currently buffered (registered)
overflow_err  out  1  sticky: flit arrived to a full VC
underflow_err  out  1  sticky: dequeue from an empty VC

Behaviour:
- Reset: all occupancy counters 0, all pending counters 0, credit_valid=0, credit=0, nearly_full=0, both error flags 0, RR pointer at VC0.
- Occupancy per VC i:
  - inc = flit_valid & flit_vc_id[i]; dec = vc_deq[i].
  - inc only: +1. dec only: -1. Both: unchanged.
  - inc with occupancy==buf_depth and no dec: counter holds, overflow_err set.
  - dec with occupancy==0 and no inc: counter holds, underflow_err set.
  - Error flags clear only on reset.
- Pending credits per VC i:
  - +1 on vc_deq[i] when that dequeue is legal; underflowing dequeues generate no credit.
  - -1 when VC i is granted.
  - deq and grant on the same VC in the same cycle: net 0.
  - Saturates at buf_depth; cannot exceed it in legal operation.
- Arbiter:
  - Request vector = pending!=0, sampled from registered pending counters (not same-cycle vc_deq).
  - Round-robin starting at the RR pointer. On grant, the pointer moves to granted VC + 1, wrapping at num_vcs. With no grant, the pointer holds.
  - Grant is registered into credit_valid/credit.
- Latency:
  - Uncontended: vc_deq[i] in cycle t → pending=1 at t+1 → grant in t+1 → credit_valid=1, credit=i in cycle t+2.
  - Sustained throughput: 1 credit per cycle.
  - credit holds its last value when credit_valid=0.
- Conservation: occupancy[i] + pending[i] + credits in flight upstream == buf_depth - upstream counter[i].
- Reset mid-operation: pending credits are discarded; upstream must be reset in the same cycle.

Optional Feature:
Macro: NEARLY_FULL_OUT_EN
- Defined:
  - nearly_full[i] is registered, equal to (next occupancy[i] >= buf_depth-1).
  - Asserts the cycle after the write that leaves one free slot.
  - Deasserts the cycle after a dequeue drops occupancy below buf_depth-1.
  - Credit logic is still present; credit_valid keeps operating.
- Not defined: nearly_full is constant 0 and the comparison logic is not instantiated.

Test Plan:
- Single credit: reset, flit to VC2, vc_deq=0100 two cycles later → credit_valid=1, credit=2 exactly 2 cycles after the deq; vc_occupancy[2] goes 0→1→0.
- Contention: vc_deq=1111 in one cycle, pointer at VC0 → credits 0,1,2,3 on 4 consecutive cycles; then pointer at 0.
- Fairness: VC1 dequeues every cycle while VC3 holds 2 pending → grants alternate 1,3,1,3 until VC3 is drained; no VC starves more than num_vcs-1 cycles.
- Simultaneous: VC0 at occupancy 4 gets flit + deq in the same cycle → occupancy stays 4, overflow_err=0, one credit for VC0 returned.
- Errors: flit to full VC1 (occupancy 4) → overflow_err=1 sticky, occupancy stays 4. Deq of empty VC3 → underflow_err=1, no credit emitted. Reset → both flags 0.
- NEARLY_FULL_OUT_EN: 3 flits to VC0 with buf_depth=4 → nearly_full[0]=1 the cycle after the 3rd flit; one deq → nearly_full[0]=0 the next cycle. Without the macro, nearly_full stays 0000 throughout.

Source files
------------

// File: rtl/nw_vc_fc_in_if.sv
// Flit-arrival / dequeue / credit-return channel between a VC input buffer
// and its flow-control block. The credit side (credit_valid/credit) and the
// optional nearly_full stop/go vector flow back toward the upstream sender.
interface nw_vc_fc_in_if #(
    parameter int NUM_VCS = 4,
    parameter int VC_BITS = $clog2(NUM_VCS)
);
    logic               flit_valid;
    logic [NUM_VCS-1:0] flit_vc_id;
    logic [NUM_VCS-1:0] vc_deq;
    logic               credit_valid;
    logic [VC_BITS-1:0] credit;
    logic [NUM_VCS-1:0] nearly_full;

    modport master (
        output flit_valid, flit_vc_id, vc_deq,
        input  credit_valid, credit, nearly_full
    );

    modport slave (
        input  flit_valid, flit_vc_id, vc_deq,
        output credit_valid, credit, nearly_full
    );
endinterface

// File: rtl/nw_vc_fc_in.sv
// Receiver-side virtual-channel flow control.
// Tracks per-VC buffer occupancy, accumulates pending credits from legal
// dequeues and returns them upstream one per cycle through a round-robin
// arbiter. Optional macro NEARLY_FULL_OUT_EN enables the registered per-VC
// nearly_full stop/go output; without it nearly_full is tied to 0.
module nw_vc_fc_in #(
    parameter int NUM_VCS   = 4,
    parameter int BUF_DEPTH = 4,
    parameter int VC_BITS   = $clog2(NUM_VCS),
    parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    nw_vc_fc_in_if.slave                   fc_if,
    output logic [NUM_VCS-1:0][CNT_W-1:0]  o_vc_occupancy,
    output logic                           o_overflow_err,
    output logic                           o_underflow_err
);

    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [VC_BITS:0]   NVC_EXT  = (VC_BITS+1)'(NUM_VCS);
    localparam logic [VC_BITS-1:0] VC_LAST  = VC_BITS'(NUM_VCS - 1);

    logic [NUM_VCS-1:0][CNT_W-1:0] r_occ;
    logic [NUM_VCS-1:0][CNT_W-1:0] r_pend;
    logic [VC_BITS-1:0]            r_ptr;
    logic                          r_credit_valid;
    logic [VC_BITS-1:0]            r_credit;
    logic                          r_ovf;
    logic                          r_unf;

    logic [NUM_VCS-1:0]            w_inc;
    logic [NUM_VCS-1:0]            w_dec;
    logic [NUM_VCS-1:0]            w_ovf;
    logic [NUM_VCS-1:0]            w_unf;
    logic [NUM_VCS-1:0]            w_crd_in;
    logic [NUM_VCS-1:0][CNT_W-1:0] w_occ_nxt;
    logic [NUM_VCS-1:0][CNT_W-1:0] w_pend_nxt;
    logic                          w_gnt_valid;
    logic [VC_BITS-1:0]            w_gnt_idx;
    logic [NUM_VCS-1:0]            w_gnt_oh;
    logic [VC_BITS:0]              w_idx;
    logic [VC_BITS-1:0]            w_ptr_nxt;

    assign w_inc = {NUM_VCS{fc_if.flit_valid}} & fc_if.flit_vc_id;
    assign w_dec = fc_if.vc_deq;

    // Round-robin pick among VCs with registered pending credits, starting at r_ptr
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        w_gnt_oh    = '0;
        w_idx       = '0;
        for (int k = 0; k < NUM_VCS; k++) begin
            w_idx = {1'b0, r_ptr} + (VC_BITS+1)'(k);
            if (w_idx >= NVC_EXT) begin
                w_idx = w_idx - NVC_EXT;
            end
            if (!w_gnt_valid && (r_pend[w_idx[VC_BITS-1:0]] != '0)) begin
                w_gnt_valid                  = 1'b1;
                w_gnt_idx                    = w_idx[VC_BITS-1:0];
                w_gnt_oh[w_idx[VC_BITS-1:0]] = 1'b1;
            end
        end
        w_ptr_nxt = r_ptr;
        if (w_gnt_valid) begin
            w_ptr_nxt = (w_gnt_idx == VC_LAST) ? '0 : w_gnt_idx + VC_BITS'(1);
        end
    end

    // Per-VC occupancy and pending-credit next state with error detection
    always_comb begin
        w_ovf      = '0;
        w_unf      = '0;
        w_crd_in   = '0;
        w_occ_nxt  = r_occ;
        w_pend_nxt = r_pend;
        for (int i = 0; i < NUM_VCS; i++) begin
            // A flit and a dequeue on the same VC cancel, even at full/empty.
            w_ovf[i]    = w_inc[i] & ~w_dec[i] & (r_occ[i] == CNT_MAX);
            w_unf[i]    = w_dec[i] & ~w_inc[i] & (r_occ[i] == '0);
            w_crd_in[i] = w_dec[i] & ~w_unf[i];
            if (w_inc[i] & ~w_dec[i] & ~w_ovf[i]) begin
                w_occ_nxt[i] = r_occ[i] + CNT_ONE;
            end else if (w_dec[i] & ~w_inc[i] & ~w_unf[i]) begin
                w_occ_nxt[i] = r_occ[i] - CNT_ONE;
            end
            if (w_crd_in[i] & ~w_gnt_oh[i]) begin
                if (r_pend[i] != CNT_MAX) begin
                    w_pend_nxt[i] = r_pend[i] + CNT_ONE;
                end
            end else if (~w_crd_in[i] & w_gnt_oh[i]) begin
                w_pend_nxt[i] = r_pend[i] - CNT_ONE;
            end
        end
    end

    // Counter and arbiter-pointer state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ  <= '0;
            r_pend <= '0;
            r_ptr  <= '0;
        end else begin
            r_occ  <= w_occ_nxt;
            r_pend <= w_pend_nxt;
            r_ptr  <= w_ptr_nxt;
        end
    end

    // Registered credit return; credit index holds when no credit is sent
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_credit_valid <= 1'b0;
            r_credit       <= '0;
        end else begin
            r_credit_valid <= w_gnt_valid;
            if (w_gnt_valid) begin
                r_credit <= w_gnt_idx;
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= r_ovf | (|w_ovf);
            r_unf <= r_unf | (|w_unf);
        end
    end

`ifdef NEARLY_FULL_OUT_EN
    localparam logic [CNT_W-1:0] NF_THR = CNT_W'(BUF_DEPTH - 1);
    logic [NUM_VCS-1:0] r_nf;

    // Stop/go: assert once the next occupancy leaves at most one free slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_nf <= '0;
        end else begin
            for (int i = 0; i < NUM_VCS; i++) begin
                r_nf[i] <= (w_occ_nxt[i] >= NF_THR);
            end
        end
    end

    assign fc_if.nearly_full = r_nf;
`else
    assign fc_if.nearly_full = '0;
`endif

    assign fc_if.credit_valid = r_credit_valid;
    assign fc_if.credit       = r_credit;
    assign o_vc_occupancy     = r_occ;
    assign o_overflow_err     = r_ovf;
    assign o_underflow_err    = r_unf;

endmodule

// File: tb/tb_nw_vc_fc_in.sv
// Scoreboard bench for nw_vc_fc_in: directed scenarios plus randomized
// traffic, checked against a buffer/credit model built from the flow rules.
module tb_nw_vc_fc_in;

    localparam int NV = 4;
    localparam int D  = 4;
    localparam int VB = $clog2(NV);
    localparam int CW = $clog2(D + 1);
`ifdef NEARLY_FULL_OUT_EN
    localparam bit NF_EN = 1'b1;
`else
    localparam bit NF_EN = 1'b0;
`endif

    typedef struct {
        int vc;
        int cyc;
    } exp_t;

    logic                     clk;
    logic                     rst_n;
    logic [NV-1:0][CW-1:0]    occ;
    logic                     ovf_err;
    logic                     unf_err;

    nw_vc_fc_in_if #(.NUM_VCS(NV)) fc_if ();

    nw_vc_fc_in #(.NUM_VCS(NV), .BUF_DEPTH(D)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fc_if           (fc_if),
        .o_vc_occupancy  (occ),
        .o_overflow_err  (ovf_err),
        .o_underflow_err (unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    int   m_occ [NV];
    int   m_pend[NV];
    int   m_ptr;
    int   m_last;
    bit   m_ovf;
    bit   m_unf;
    int   cyc;
    exp_t exp_q[$];

    int n_checks;
    int n_errors;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int g;
        bit inc, dec;
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < NV; i++) begin
                m_occ[i]  = 0;
                m_pend[i] = 0;
            end
            m_ptr  = 0;
            m_last = 0;
            m_ovf  = 0;
            m_unf  = 0;
            return;
        end
        g = -1;
        for (int k = 0; k < NV; k++) begin
            if (g < 0 && m_pend[(m_ptr + k) % NV] > 0) g = (m_ptr + k) % NV;
        end
        if (g >= 0) begin
            exp_q.push_back('{vc: g, cyc: cyc});
            m_pend[g]--;
            m_ptr  = (g + 1) % NV;
            m_last = g;
        end
        for (int i = 0; i < NV; i++) begin
            inc = fc_if.flit_valid && fc_if.flit_vc_id[i];
            dec = fc_if.vc_deq[i];
            if (inc && dec) begin
                if (m_pend[i] < D) m_pend[i]++;
            end else if (inc) begin
                if (m_occ[i] == D) m_ovf = 1;
                else m_occ[i]++;
            end else if (dec) begin
                if (m_occ[i] == 0) m_unf = 1;
                else begin
                    m_occ[i]--;
                    if (m_pend[i] < D) m_pend[i]++;
                end
            end
        end
    endtask

    task automatic drive(input bit fv, input logic [NV-1:0] id, input logic [NV-1:0] dq);
        fc_if.flit_valid = fv;
        fc_if.flit_vc_id = id;
        fc_if.vc_deq     = dq;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0);
    endtask

    task automatic flit(input int vc);
        logic [NV-1:0] oh;
        oh     = '0;
        oh[vc] = 1'b1;
        drive(1'b1, oh, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    // Monitor: compare DUT outputs with the model on every falling edge.
    initial begin
        bit   exp_v;
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                n_errors++;
                $display("FAIL credit_missed: vc %0d expected in cycle %0d", e.vc, e.cyc);
            end
            exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            chk("credit_valid", 64'(fc_if.credit_valid), 64'(exp_v));
            if (exp_v && fc_if.credit_valid) begin
                e = exp_q.pop_front();
                chk("credit_vc", 64'(fc_if.credit), 64'(e.vc));
            end else if (!exp_v && !fc_if.credit_valid) begin
                chk("credit_hold", 64'(fc_if.credit), 64'(m_last));
            end
            for (int i = 0; i < NV; i++) begin
                chk("occupancy", 64'(occ[i]), 64'(m_occ[i]));
                chk("nearly_full", 64'(fc_if.nearly_full[i]),
                    64'(NF_EN && (m_occ[i] >= D - 1)));
            end
            chk("overflow_err", 64'(ovf_err), 64'(m_ovf));
            chk("underflow_err", 64'(unf_err), 64'(m_unf));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        m_ptr    = 0;
        m_last   = 0;
        m_ovf    = 0;
        m_unf    = 0;
        for (int i = 0; i < NV; i++) begin
            m_occ[i]  = 0;
            m_pend[i] = 0;
        end
        rst_n            = 1'b0;
        fc_if.flit_valid = 1'b0;
        fc_if.flit_vc_id = '0;
        fc_if.vc_deq     = '0;
        do_reset();

        // reset state
        chk("rst_credit_valid", 64'(fc_if.credit_valid), 64'd0);
        chk("rst_credit", 64'(fc_if.credit), 64'd0);
        chk("rst_errs", 64'({ovf_err, unf_err}), 64'd0);
        chk("rst_occ", 64'(occ), 64'd0);

        // single credit on VC2
        flit(2);
        chk("single_occ_up", 64'(occ[2]), 64'd1);
        idle(1);
        drive(1'b0, '0, 4'b0100);
        chk("single_occ_down", 64'(occ[2]), 64'd0);
        idle(1);
        chk("single_credit_t2", 64'({fc_if.credit_valid, fc_if.credit}), 64'({1'b1, 2'd2}));
        idle(2);

        // contention: all four VCs dequeue together
        for (int v = 0; v < NV; v++) flit(v);
        drive(1'b0, '0, 4'b1111);
        idle(6);
        drive(1'b0, '0, 4'b0011);
        idle(4);

        // fairness: VC1 dequeues every cycle while VC3 builds up two credits
        for (int n = 0; n < 4; n++) flit(1);
        flit(3);
        flit(3);
        drive(1'b0, '0, 4'b1010);
        drive(1'b0, '0, 4'b1010);
        drive(1'b0, '0, 4'b0010);
        drive(1'b0, '0, 4'b0010);
        idle(6);

        // simultaneous flit + dequeue on a full VC0
        for (int n = 0; n < D; n++) flit(0);
        drive(1'b1, 4'b0001, 4'b0001);
        chk("simul_occ", 64'(occ[0]), 64'(D));
        chk("simul_ovf", 64'(ovf_err), 64'd0);
        idle(4);

        // error flags
        do_reset();
        for (int n = 0; n < D; n++) flit(1);
        flit(1);
        chk("ovf_set", 64'(ovf_err), 64'd1);
        chk("ovf_occ_hold", 64'(occ[1]), 64'(D));
        drive(1'b0, '0, 4'b1000);
        chk("unf_set", 64'(unf_err), 64'd1);
        idle(3);
        chk("ovf_sticky", 64'(ovf_err), 64'd1);
        do_reset();
        chk("errs_cleared", 64'({ovf_err, unf_err}), 64'd0);

        // nearly_full on VC0
        for (int n = 0; n < 3; n++) flit(0);
        chk("nf_assert", 64'(fc_if.nearly_full[0]), 64'(NF_EN));
        drive(1'b0, '0, 4'b0001);
        chk("nf_deassert", 64'(fc_if.nearly_full[0]), 64'd0);
        idle(3);
        do_reset();

        // randomized traffic with occasional errors and mid-run resets
        for (int c = 0; c < 2000; c++) begin
            int            vc;
            bit            fv;
            logic [NV-1:0] id;
            logic [NV-1:0] dq;
            if (c % 500 == 499) begin
                rst_n = 1'b0;
                idle(1);
                rst_n = 1'b1;
                continue;
            end
            vc = int'($urandom_range(NV - 1));
            fv = ($urandom_range(99) < 45) && (m_occ[vc] < D || $urandom_range(99) < 5);
            if (fv) begin
                id     = '0;
                id[vc] = 1'b1;
            end else begin
                id = NV'($urandom);
            end
            dq = '0;
            for (int i = 0; i < NV; i++) begin
                if ($urandom_range(99) < 30 && (m_occ[i] > 0 || $urandom_range(99) < 5))
                    dq[i] = 1'b1;
            end
            drive(fv, id, dq);
        end

        idle(12);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
